// File: rtl/fir_mac_param.sv
// Time-multiplexed single-MAC FIR filter with a valid/ready input and a post-reset buffer clear.
// Define FIR_OUT_SAT_EN to round, shift right by SHIFT and saturate y to the signed DATA_W range.
module fir_mac_param #(
    parameter int unsigned TAPS    = 31,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned COEFF_W = 10,
    parameter int unsigned ACC_W   = 23,
    parameter int unsigned SHIFT   = 10,
    localparam int unsigned IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [DATA_W-1:0]  x,
    input  logic signed [COEFF_W-1:0] coeff,
    output logic [IDX_W-1:0]          idx,
    output logic signed [ACC_W-1:0]   y,
    output logic                      y_valid,
    output logic                      busy
);

    localparam int unsigned      PROD_W = DATA_W + COEFF_W;
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(TAPS - 1);
    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);

    if (TAPS < 2 || TAPS > 256 || SHIFT >= ACC_W) begin : g_bad_params
        $error("fir_mac_param: unsupported parameter combination");
    end

    typedef enum logic [1:0] {StClear, StIdle, StMac} state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         clr_cnt_q, clr_cnt_d;
    logic [IDX_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  y_q, y_d;
    logic                     y_valid_q, y_valid_d;

    logic signed [DATA_W-1:0] buf_mem [TAPS];
    logic                     buf_we;
    logic [IDX_W-1:0]         buf_waddr;
    logic signed [DATA_W-1:0] buf_wdata;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  y_next;

    // Full-precision product, then two's complement accumulation that wraps at ACC_W.
    assign prod    = PROD_W'(coeff) * PROD_W'(buf_mem[rd_ptr_q]);
    assign acc_sum = acc_q + ACC_W'(prod);

`ifdef FIR_OUT_SAT_EN
    localparam int unsigned             EXT_W   = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] RND     = (SHIFT > 0) ? EXT_W'(1) << (SHIFT - 1) : '0;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [EXT_W-1:0] rnd_sum;
    logic signed [EXT_W-1:0] shifted;

    // One extra bit so the rounding offset cannot overflow before the shift.
    always_comb begin
        rnd_sum = EXT_W'(acc_sum) + RND;
        shifted = rnd_sum >>> SHIFT;
        if (shifted > SAT_MAX) begin
            y_next = ACC_W'(SAT_MAX);
        end else if (shifted < SAT_MIN) begin
            y_next = ACC_W'(SAT_MIN);
        end else begin
            y_next = ACC_W'(shifted);
        end
    end
`else
    assign y_next = acc_sum;
`endif

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        y_d       = y_q;
        y_valid_d = 1'b0;
        buf_we    = 1'b0;
        buf_waddr = wr_ptr_q;
        buf_wdata = x;

        if (flush) begin
            state_d   = StClear;
            clr_cnt_d = '0;
            wr_ptr_d  = '0;
            idx_d     = '0;
        end else begin
            unique case (state_q)
                StClear: begin
                    buf_we    = 1'b1;
                    buf_waddr = clr_cnt_q;
                    buf_wdata = '0;
                    if (clr_cnt_q == LAST) begin
                        state_d   = StIdle;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ONE;
                    end
                end
                StIdle: begin
                    if (in_valid) begin
                        buf_we   = 1'b1;
                        rd_ptr_d = wr_ptr_q;
                        acc_d    = '0;
                        idx_d    = '0;
                        state_d  = StMac;
                    end
                end
                StMac: begin
                    acc_d    = acc_sum;
                    rd_ptr_d = (rd_ptr_q == '0) ? LAST : rd_ptr_q - ONE;
                    if (idx_q == LAST) begin
                        y_d       = y_next;
                        y_valid_d = 1'b1;
                        wr_ptr_d  = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + ONE;
                        idx_d     = '0;
                        state_d   = StIdle;
                    end else begin
                        idx_d = idx_q + ONE;
                    end
                end
                default: begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                    wr_ptr_d  = '0;
                    idx_d     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    // Sample storage has no reset; the CLEAR sweep zeroes it after reset and flush.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            buf_mem[buf_waddr] <= buf_wdata;
        end
    end

    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);
    assign idx      = idx_q;
    assign y        = y_q;
    assign y_valid  = y_valid_q;

endmodule

// File: tb/tb_fir_mac_param.sv
// Self-checking bench for fir_mac_param: queue-based filter model plus literal scenario checks.
module tb_fir_mac_param;

    localparam int unsigned TAPS    = 31;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COEFF_W = 10;
    localparam int unsigned ACC_W   = 23;
    localparam int unsigned SHIFT   = 10;
    localparam int unsigned IDX_W   = 5;
    localparam int          T       = TAPS;
`ifdef FIR_OUT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n, flush, in_valid, in_ready, y_valid, busy;
    logic signed [DATA_W-1:0]  x;
    logic signed [COEFF_W-1:0] coeff;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   y;
    logic signed [COEFF_W-1:0] rom [TAPS];

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     ready_from = 1 << 30;
    int     pend_cyc = -1;
    int     n_acc = 0;
    bit     was_low = 1'b1;
    longint exp_y = 0;
    longint pend_y = 0;
    longint hist[$];

    always #5 clock = ~clock;
    assign coeff = rom[idx];

    fir_mac_param #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEFF_W(COEFF_W), .ACC_W(ACC_W), .SHIFT(SHIFT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .x(x), .coeff(coeff), .idx(idx), .y(y), .y_valid(y_valid),
        .busy(busy)
    );

    task automatic chk(input string nm, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // y[n] = sum coeff[k]*x[n-k] over the sample history, wrapped to ACC_W, optionally saturated.
    function automatic longint model_y();
        longint s = 0;
        longint w;
        for (int k = 0; k < hist.size(); k++) s += longint'(rom[k]) * hist[k];
        w = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
`ifdef FIR_OUT_SAT_EN
        w = (w + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
        if (w > (64'sd1 <<< (DATA_W - 1)) - 1) w = (64'sd1 <<< (DATA_W - 1)) - 1;
        if (w < -(64'sd1 <<< (DATA_W - 1))) w = -(64'sd1 <<< (DATA_W - 1));
`endif
        return w;
    endfunction

    // Model: tracks when the block is ready, when the next result is due, and its value.
    initial forever begin
        @(posedge clock);
        cyc++;
        if (!reset_n) begin
            was_low    = 1'b1;
            ready_from = 1 << 30;
            pend_cyc   = -1;
            exp_y      = 0;
            hist.delete();
        end else if (was_low) begin
            was_low    = 1'b0;
            ready_from = cyc + T - 1;
        end else if (flush) begin
            ready_from = cyc + T;
            pend_cyc   = -1;
            hist.delete();
        end else begin
            if (cyc == pend_cyc) exp_y = pend_y;
            if (in_valid && (cyc - 1 >= ready_from)) begin
                hist.push_front(longint'(x));
                if (hist.size() > T) void'(hist.pop_back());
                pend_y     = model_y();
                pend_cyc   = cyc + T;
                ready_from = cyc + T;
                n_acc++;
            end
        end
    end

    initial forever begin
        @(negedge clock);
        if (!reset_n) begin
            chk("rst_y", y, 0);
            chk("rst_y_valid", y_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_busy", busy, 1);
            chk("rst_idx", idx, 0);
        end else begin
            chk("in_ready", in_ready, cyc >= ready_from);
            chk("busy", busy, cyc < ready_from);
            chk("y_valid", y_valid, cyc == pend_cyc);
            chk("y", y, exp_y);
            chk("idx", idx, (pend_cyc >= 0 && cyc < pend_cyc) ? cyc - (pend_cyc - T) : 0);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input int v);
        int n0 = n_acc;
        int t = 0;
        x = DATA_W'(v);
        in_valid = 1'b1;
        while (n_acc == n0 && t < 200) begin
            step();
            t++;
        end
        in_valid = 1'b0;
        x = DATA_W'($urandom);
        chk("accept", n_acc - n0, 1);
    endtask

    task automatic wait_res();
        repeat (T) step();
    endtask

    task automatic wait_ready();
        int t = 0;
        while (cyc < ready_from && t < 200) begin
            step();
            t++;
        end
        chk("ready_wait", cyc >= ready_from, 1);
    endtask

    task automatic ready_delay();
        int n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk("ready_delay", n, T);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        reset_n  = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        foreach (rom[k]) rom[k] = '0;
        #1 reset_n = 1'b0;
        repeat (3) step();
        #2 reset_n = 1'b1;
        ready_delay();

        // Impulse response with coeff = idx+1.
        foreach (rom[k]) rom[k] = COEFF_W'(k + 1);
        for (int i = 0; i < 41; i++) begin
            send(i == 0 ? 1 : 0);
            wait_res();
            chk("impulse_y", y, SAT ? 0 : (i < T ? i + 1 : 0));
        end

        // in_valid held high: one acceptance per TAPS+1 cycles.
        foreach (rom[k]) rom[k] = COEFF_W'($urandom);
        n0 = n_acc;
        in_valid = 1'b1;
        for (int i = 0; i < 5 * (T + 1); i++) begin
            x = DATA_W'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("throughput", n_acc - n0, 5);
        repeat (T + 1) step();

        // Signed extremes.
        foreach (rom[k]) rom[k] = COEFF_W'(SAT ? 511 : -512);
        for (int i = 0; i < T; i++) begin
            send(SAT ? 127 : -128);
            wait_res();
        end
        chk("extreme_y", y, SAT ? 127 : 2031616);

        // Delay line: only the oldest tap is non-zero, ramp input across pointer wraps.
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_ready();
        foreach (rom[k]) rom[k] = '0;
        rom[T-1] = COEFF_W'(1);
        for (int n = 0; n < 61; n++) begin
            send(n);
            wait_res();
            chk("wrap_y", y, SAT ? 0 : (n >= T - 1 ? n - (T - 1) : 0));
        end

        // Flush in the middle of a MAC pass, then the impulse must match a clean buffer.
        foreach (rom[k]) rom[k] = COEFF_W'(k + 1);
        send($urandom_range(1, 100));
        repeat (12) step();
        chk("flush_idx", idx, 12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_ready();
        for (int i = 0; i < T + 1; i++) begin
            send(i == 0 ? 1 : 0);
            wait_res();
            chk("post_flush_y", y, SAT ? 0 : (i < T ? i + 1 : 0));
        end

        // Asynchronous reset in the middle of a MAC pass.
        send($urandom_range(1, 100));
        repeat (20) step();
        chk("pre_rst_idx", idx, 20);
        #2 reset_n = 1'b0;
        #1;
        chk("async_y", y, 0);
        chk("async_y_valid", y_valid, 0);
        chk("async_in_ready", in_ready, 0);
        chk("async_busy", busy, 1);
        repeat (2) step();
        #2 reset_n = 1'b1;
        ready_delay();

        // Random traffic with occasional flushes.
        foreach (rom[k]) rom[k] = COEFF_W'($urandom);
        for (int i = 0; i < 1500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            x        = DATA_W'($urandom);
            flush    = ($urandom_range(0, 149) == 0);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (T + 2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
